sensor_scanner: RTL

Sequencing front-end that drives the 2-bit select of the home-automation 4:1 sensor multiplexer and consumes its single-bit output. It steps through the four sensor channels, waits for the mux path to settle, samples and debounces each input, and keeps a registered 4-bit status word. Each debounced change is reported to the controller over a single-entry valid/ready event port.

---
 rtl/sensor_scanner.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sensor_scanner.sv
// Steps a 4:1 sensor mux, waits for the path to settle, debounces each channel and reports changes.
// Latency: SETTLE_CYCLES+2 cycles per channel; status/event update on the edge ending the committing sample.
// Backpressure: a commit against a full, unaccepted event slot holds the scanner in SAMPLE until the slot frees.
module sensor_scanner #(
    parameter int SETTLE_CYCLES = 4,
    parameter int DEBOUNCE      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [1:0] sel,
    input  logic       mux_out,
    output logic [3:0] status,
    output logic       event_valid,
    input  logic       event_ready,
    output logic [1:0] event_ch,
    output logic       event_level,
    output logic       scan_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        NEXT   = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] DEB_LAST    = 4'(DEBOUNCE - 1);

    state_t          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [3:0]      status_q, status_d;
    logic [3:0][3:0] cnt_q, cnt_d;
    logic [7:0]      settle_q, settle_d;
    logic            ev_vld_q, ev_vld_d;
    logic [1:0]      ev_ch_q, ev_ch_d;
    logic            ev_lvl_q, ev_lvl_d;
    logic            scan_done_q, scan_done_d;

    logic same;
    logic commit;
    logic stall;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        status_d    = status_q;
        cnt_d       = cnt_q;
        settle_d    = settle_q;
        ev_vld_d    = ev_vld_q;
        ev_ch_d     = ev_ch_q;
        ev_lvl_d    = ev_lvl_q;
        scan_done_d = 1'b0;

        same   = (mux_out == status_q[sel_q]);
        commit = !same && (cnt_q[sel_q] == DEB_LAST);
        // Only a commit needs the slot; plain counting never stalls.
        stall  = commit && ev_vld_q && !event_ready;

        if (ev_vld_q && event_ready) begin
            ev_vld_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                sel_d = 2'd0;
                if (en) begin
                    state_d  = SETTLE;
                    settle_d = 8'd0;
                end
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = 8'd0;
                    state_d  = SAMPLE;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            SAMPLE: begin
                if (!stall) begin
                    if (same) begin
                        cnt_d[sel_q] = 4'd0;
                    end else if (commit) begin
                        status_d[sel_q] = mux_out;
                        cnt_d[sel_q]    = 4'd0;
                        ev_vld_d        = 1'b1;
                        ev_ch_d         = sel_q;
                        ev_lvl_d        = mux_out;
                    end else begin
                        cnt_d[sel_q] = cnt_q[sel_q] + 4'd1;
                    end
                    state_d = NEXT;
                end
            end
            NEXT: begin
                sel_d    = sel_q + 2'd1;
                settle_d = 8'd0;
                state_d  = SETTLE;
                if (sel_q == 2'd3) begin
                    scan_done_d = 1'b1;
                    // en is only honoured at scan boundaries, so a drop mid-scan lets the scan finish.
                    if (!en) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= 2'd0;
            status_q    <= 4'd0;
            cnt_q       <= '0;
            settle_q    <= 8'd0;
            ev_vld_q    <= 1'b0;
            ev_ch_q     <= 2'd0;
            ev_lvl_q    <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            status_q    <= status_d;
            cnt_q       <= cnt_d;
            settle_q    <= settle_d;
            ev_vld_q    <= ev_vld_d;
            ev_ch_q     <= ev_ch_d;
            ev_lvl_q    <= ev_lvl_d;
            scan_done_q <= scan_done_d;
        end
    end

    assign sel         = sel_q;
    assign status      = status_q;
    assign event_valid = ev_vld_q;
    assign event_ch    = ev_ch_q;
    assign event_level = ev_lvl_q;
    assign scan_done   = scan_done_q;

endmodule
